// File: rtl/integral_window_builder.sv
// Builds the integral image of one WIN x WIN raster-order window, one entry per accepted pixel,
// streaming (ii, row, col) out through a valid/ready output register.
module integral_window_builder #(
  parameter int unsigned WIN   = 20,
  parameter int unsigned PIX_W = 8,
  parameter int unsigned II_W  = 17
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [II_W-1:0]  integral_output,
  output logic [4:0]       address_i,
  output logic [4:0]       address_j,
  output logic             read_write,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  localparam logic [4:0] LastIdx = 5'(WIN - 1);

  state_e state_q, state_d;

  logic [4:0]      i_q, j_q;
  logic            last_q;
  logic [II_W-1:0] rowsum_q;
  logic [II_W-1:0] row_buf_q [WIN];
  logic [II_W-1:0] ii_q;
  logic [4:0]      ai_q, aj_q;
  logic            ov_q;

  logic            pix_acc, last_hs;
  logic [II_W-1:0] rowsum_new, above, ii_new;

  always_comb begin
    pix_acc    = pix_valid && pix_ready;
    last_hs    = ov_q && out_ready && (ai_q == LastIdx) && (aj_q == LastIdx);
    rowsum_new = ((j_q == '0) ? '0 : rowsum_q) + II_W'(pix_in);
    // Row 0 has nothing above it; the buffer contents are ignored there.
    above      = (i_q == '0) ? '0 : row_buf_q[j_q];
    ii_new     = rowsum_new + above;
  end

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StLoad;
      StLoad:  if (last_hs) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    // last_q stops intake once the final entry is in the output register.
    pix_ready       = (state_q == StLoad) && !last_q && (!ov_q || out_ready);
    read_write      = (state_q != StIdle);
    done            = (state_q == StDone);
    out_valid       = ov_q;
    integral_output = ii_q;
    address_i       = ai_q;
    address_j       = aj_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      i_q      <= '0;
      j_q      <= '0;
      last_q   <= 1'b0;
      rowsum_q <= '0;
      ii_q     <= '0;
      ai_q     <= '0;
      aj_q     <= '0;
      ov_q     <= 1'b0;
      for (int k = 0; k < int'(WIN); k++) row_buf_q[k] <= '0;
    end else begin
      if (state_q == StIdle && start) begin
        i_q      <= '0;
        j_q      <= '0;
        last_q   <= 1'b0;
        rowsum_q <= '0;
      end else if (pix_acc) begin
        rowsum_q       <= rowsum_new;
        row_buf_q[j_q] <= ii_new;
        ii_q           <= ii_new;
        ai_q           <= i_q;
        aj_q           <= j_q;
        if (j_q == LastIdx) begin
          j_q <= '0;
          if (i_q == LastIdx) begin
            i_q    <= '0;
            last_q <= 1'b1;
          end else begin
            i_q <= i_q + 5'd1;
          end
        end else begin
          j_q <= j_q + 5'd1;
        end
      end

      if (pix_acc)                ov_q <= 1'b1;
      else if (ov_q && out_ready) ov_q <= 1'b0;
    end
  end

endmodule
